// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: access FSM encoding and
// register-file / alignment constants.
package mem_wb_stage_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } state_e;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] WordAlignMask = 2'b11;

    // $0 is hard-wired to zero and must never be written.
    localparam logic [4:0] RegZero = 5'd0;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] & WordAlignMask) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack port between the MEM/WB stage and the memory.
interface mem_wb_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_wb_stage_dmem_access_fsm.sv
// Data-memory access sequencer: holds the pipeline while a request is
// outstanding and aborts with a bus error when the memory never answers.
module mem_wb_stage_dmem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic memop_i,    // live load/store presented by EX/MEM
    input  logic aligned_i,  // its address is word aligned
    input  logic ack_i,
    output logic idle_o,
    output logic req_o,
    output logic stall_o,
    output logic done_o,     // access completes at this edge
    output logic bus_err_o
);

    localparam int unsigned CntW = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            bus_err_q;
    logic            in_access;
    logic            expired;

    assign in_access = (state_q == StAccess);
    // Ack wins over an expiring counter: a completed transfer is kept.
    assign expired   = in_access && !ack_i && (cnt_q == CntMax);

    // Stall/request decode from current state and memory handshake.
    always_comb begin
        idle_o  = !in_access;
        req_o   = in_access;
        done_o  = in_access && ack_i;
        stall_o = 1'b0;
        if (!in_access) begin
            stall_o = memop_i && aligned_i;
        end else begin
            stall_o = !ack_i && !expired;
        end
    end

    // State, wait counter and registered bus-error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (memop_i && aligned_i) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (ack_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (expired) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus_err_o = bus_err_q;

endmodule

// File: rtl/mem_wb_stage_reg.sv
// Pipeline register cell with load enable and asynchronous active-low clear.
module mem_wb_stage_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    // Load on enable, clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB end of the 5-stage pipeline: performs loads/stores over the dmem
// port, registers write-back results and drives the register-file write port.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_alu_result,
    input  logic [31:0]           ex_store_data,
    input  logic [4:0]            ex_write_reg,
    input  logic                  ex_RegWrite,
    input  logic                  ex_memRead,
    input  logic                  ex_memWrite,
    input  logic                  ex_memtoReg,
    mem_wb_stage_if.master        dmem,
    output logic                  stall,
    output logic [4:0]            writeReg,
    output logic [31:0]           writeData,
    output logic                  RegWriteFinal,
    output logic                  align_err,
    output logic                  bus_err,
    output logic [31:0]           retired
);

    logic        memop;
    logic        aligned;
    logic        fsm_idle;
    logic        fsm_req;
    logic        fsm_done;
    logic        alu_retire;
    logic        align_drop;
    logic        wb_en;
    logic        retire_any;
    logic [31:0] wb_data_d;
    logic        rwf_d;
    logic [31:0] retired_d;

    assign memop   = ex_valid && (ex_memRead || ex_memWrite);
    assign aligned = is_word_aligned(ex_alu_result);

    mem_wb_stage_dmem_access_fsm #(
        .TimeoutCycles (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk_i     (clk),
        .rst_ni    (rst),
        .memop_i   (memop),
        .aligned_i (aligned),
        .ack_i     (dmem.dmem_ack),
        .idle_o    (fsm_idle),
        .req_o     (fsm_req),
        .stall_o   (stall),
        .done_o    (fsm_done),
        .bus_err_o (bus_err)
    );

    // The EX/MEM bundle is frozen by stall, so the request fields come
    // straight from it. Both memRead and memWrite set resolves to a write.
    assign dmem.dmem_req   = fsm_req;
    assign dmem.dmem_we    = ex_memWrite;
    assign dmem.dmem_addr  = ex_alu_result;
    assign dmem.dmem_wdata = ex_store_data;

    // Retirement and write-back selection for this edge.
    always_comb begin
        alu_retire = fsm_idle && ex_valid && !memop;
        align_drop = fsm_idle && memop && !aligned;
        wb_en      = alu_retire || fsm_done;
        retire_any = wb_en || align_drop;
        wb_data_d  = ex_memtoReg ? dmem.dmem_rdata : ex_alu_result;
        rwf_d      = wb_en && ex_RegWrite && !ex_memWrite && (ex_write_reg != RegZero);
        retired_d  = retired + 32'd1;
    end

    mem_wb_stage_reg #(.Width(5)) u_write_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (wb_en),
        .d_i    (ex_write_reg),
        .q_o    (writeReg)
    );

    mem_wb_stage_reg #(.Width(32)) u_write_data (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (wb_en),
        .d_i    (wb_data_d),
        .q_o    (writeData)
    );

    mem_wb_stage_reg #(.Width(1)) u_reg_write (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (1'b1),
        .d_i    (rwf_d),
        .q_o    (RegWriteFinal)
    );

    mem_wb_stage_reg #(.Width(1)) u_align_err (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (1'b1),
        .d_i    (align_drop),
        .q_o    (align_err)
    );

    mem_wb_stage_reg #(.Width(32)) u_retired (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (retire_any),
        .d_i    (retired_d),
        .q_o    (retired)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: single-cycle vectors from a table, plus
// hand-written load, store, timeout and mid-access reset sequences.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_write_reg;
    logic        ex_RegWrite;
    logic        ex_memRead;
    logic        ex_memWrite;
    logic        ex_memtoReg;
    logic        stall;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWriteFinal;
    logic        align_err;
    logic        bus_err;
    logic [31:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage_if dif ();

    mem_wb_stage #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_write_reg  (ex_write_reg),
        .ex_RegWrite   (ex_RegWrite),
        .ex_memRead    (ex_memRead),
        .ex_memWrite   (ex_memWrite),
        .ex_memtoReg   (ex_memtoReg),
        .dmem          (dif),
        .stall         (stall),
        .writeReg      (writeReg),
        .writeData     (writeData),
        .RegWriteFinal (RegWriteFinal),
        .align_err     (align_err),
        .bus_err       (bus_err),
        .retired       (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        e_rwf;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_align;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] w, input logic rw, input logic mr,
                         input logic mw, input logic m2r);
        ex_valid      = v;
        ex_alu_result = a;
        ex_store_data = s;
        ex_write_reg  = w;
        ex_RegWrite   = rw;
        ex_memRead    = mr;
        ex_memWrite   = mw;
        ex_memtoReg   = m2r;
    endtask

    initial begin
        int n_stall;

        //         name        v   alu           wreg rw mr mw m2r rwf wreg  wdata         al ret
        vecs[0] = '{"alu_r8",   1, 32'h0000_002A, 8,  1, 0, 0, 0,  1, 8,  32'h0000_002A, 0, 1};
        vecs[1] = '{"lw_mis",   1, 32'h0000_0103, 9,  1, 1, 0, 1,  0, 8,  32'h0000_002A, 1, 2};
        vecs[2] = '{"alu_r0",   1, 32'h0000_0055, 0,  1, 0, 0, 0,  0, 0,  32'h0000_0055, 0, 3};
        vecs[3] = '{"bubble",   0, 32'h0000_0077, 3,  1, 0, 0, 0,  0, 0,  32'h0000_0055, 0, 3};
        vecs[4] = '{"alu_norw", 1, 32'hFFFF_FFFF, 31, 0, 0, 0, 0,  0, 31, 32'hFFFF_FFFF, 0, 4};
        vecs[5] = '{"sw_mis",   1, 32'h0000_0202, 4,  0, 0, 1, 0,  0, 31, 32'hFFFF_FFFF, 1, 5};
        vecs[6] = '{"alu_r5",   1, 32'h1234_5678, 5,  1, 0, 0, 0,  1, 5,  32'h1234_5678, 0, 6};

        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dif.dmem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rwf", 32'(RegWriteFinal), 32'd0);
        check("rst_wreg", 32'(writeReg), 32'd0);
        check("rst_wdata", writeData, 32'd0);
        check("rst_retired", retired, 32'd0);
        rst = 1'b1;

        // Single-cycle operations: ALU, misaligned, $0, bubble.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].valid, vecs[i].alu, 32'hCAFE_0000, vecs[i].wreg, vecs[i].rw,
                  vecs[i].mr, vecs[i].mw, vecs[i].m2r);
            #1;
            check({vecs[i].name, "_stall"}, 32'(stall), 32'd0);
            check({vecs[i].name, "_req"}, 32'(dif.dmem_req), 32'd0);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_rwf"}, 32'(RegWriteFinal), 32'(vecs[i].e_rwf));
            check({vecs[i].name, "_wreg"}, 32'(writeReg), 32'(vecs[i].e_wreg));
            check({vecs[i].name, "_wdata"}, writeData, vecs[i].e_wdata);
            check({vecs[i].name, "_align"}, 32'(align_err), 32'(vecs[i].e_align));
            check({vecs[i].name, "_ret"}, retired, vecs[i].e_ret);
        end

        // Load, ack arrives in the fourth ACCESS cycle.
        drive(1, 32'h0000_0100, 32'h0, 5'd9, 1, 1, 0, 1);
        #1;
        check("lw_idle_stall", 32'(stall), 32'd1);
        check("lw_idle_req", 32'(dif.dmem_req), 32'd0);
        @(posedge clk);
        #2;
        check("lw_req", 32'(dif.dmem_req), 32'd1);
        check("lw_we", 32'(dif.dmem_we), 32'd0);
        check("lw_addr", dif.dmem_addr, 32'h0000_0100);
        check("lw_a1_stall", 32'(stall), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #2;
            check("lw_wait_stall", 32'(stall), 32'd1);
        end
        @(posedge clk);
        #1;
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("lw_ack_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = 32'h0;
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        check("lw_rwf", 32'(RegWriteFinal), 32'd1);
        check("lw_wreg", 32'(writeReg), 32'd9);
        check("lw_wdata", writeData, 32'hDEAD_BEEF);
        check("lw_ret", retired, 32'd7);

        // Zero-wait store with RegWrite set: still no register write.
        drive(1, 32'h0000_0200, 32'h0000_1234, 5'd10, 1, 0, 1, 0);
        #1;
        check("sw_idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        dif.dmem_ack = 1'b1;
        #1;
        check("sw_req", 32'(dif.dmem_req), 32'd1);
        check("sw_we", 32'(dif.dmem_we), 32'd1);
        check("sw_wdata", dif.dmem_wdata, 32'h0000_1234);
        check("sw_addr", dif.dmem_addr, 32'h0000_0200);
        check("sw_ack_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        dif.dmem_ack = 1'b0;
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        check("sw_rwf", 32'(RegWriteFinal), 32'd0);
        check("sw_ret", retired, 32'd8);
        check("sw_buserr", 32'(bus_err), 32'd0);

        // Timeout: no ack ever; stall must last exactly five cycles.
        drive(1, 32'h0000_0300, 32'h0, 5'd11, 1, 1, 0, 1);
        #1;
        n_stall = 0;
        for (int k = 0; k < 10; k++) begin
            if (!stall) break;
            n_stall++;
            @(posedge clk);
            #2;
        end
        check("to_stall_cycles", 32'(n_stall), 32'd5);
        check("to_buserr_early", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        check("to_buserr", 32'(bus_err), 32'd1);
        check("to_rwf", 32'(RegWriteFinal), 32'd0);
        check("to_ret", retired, 32'd8);
        drive(1, 32'h0000_0ABC, 32'h0, 5'd12, 1, 0, 0, 0);
        #1;
        check("to_next_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("to_buserr_pulse", 32'(bus_err), 32'd0);
        check("to_next_rwf", 32'(RegWriteFinal), 32'd1);
        check("to_next_wreg", 32'(writeReg), 32'd12);
        check("to_next_wdata", writeData, 32'h0000_0ABC);
        check("to_next_ret", retired, 32'd9);

        // Reset while a load is outstanding.
        drive(1, 32'h0000_0400, 32'h0, 5'd13, 1, 1, 0, 1);
        @(posedge clk);
        #2;
        check("mr_req", 32'(dif.dmem_req), 32'd1);
        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        #1;
        check("mr_req_clr", 32'(dif.dmem_req), 32'd0);
        check("mr_stall", 32'(stall), 32'd0);
        check("mr_wreg", 32'(writeReg), 32'd0);
        check("mr_wdata", writeData, 32'd0);
        check("mr_ret", retired, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 32'h0000_0099, 32'h0, 5'd7, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check("post_rst_rwf", 32'(RegWriteFinal), 32'd1);
        check("post_rst_wdata", writeData, 32'h0000_0099);
        check("post_rst_ret", retired, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
